// File: rtl/nand_exerciser.sv
// Stimulus/check engine for a 2-input NAND gate: walks {A,B} through 0..3 and
// records per-vector mismatches. Define NAND_EXERCISER_SYNC_EN to synchronize gate_y.
module nand_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  logic [1:0] state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       y_cmp;
  logic       exp_y;

`ifdef NAND_EXERCISER_SYNC_EN
  // Two-flop synchronizer; the settle window already covers its latency.
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], gate_y};
  end
  assign y_cmp = sync_q[1];
`else
  assign y_cmp = gate_y;
`endif

  assign exp_y = ~(vec_q[1] & vec_q[0]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == SETTLE_LAST) state_d = S_SAMPLE;
      end
      default: begin
        // Only four samples per run, so err_count tops out at 4 by construction.
        if (y_cmp != exp_y) begin
          err_d          = err_q + 3'd1;
          fail_d[vec_q]  = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign gate_a    = vec_q[1];
  assign gate_b    = vec_q[0];
  assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 3'd0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
